// File: rtl/iob_vexriscv_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : iob_vexriscv_bus_bridge
// Purpose  : Bridges one VexRiscv simple-bus port (cmd valid/ready, rsp
//            valid) to the IOb native bus (valid held until ready). Adds cmd
//            backpressure, 32/64/128-bit memory width with byte-lane
//            steering, misalignment detection and an optional request
//            timeout that aborts with an error response.
// Ports    : i_clk, i_rst_n        clock, asynchronous active-low reset
//            i_cpu_cmd_*           CPU command (valid/ready handshake)
//            o_cpu_rsp_*           CPU read response (one-cycle strobe)
//            o_wr_err              one-cycle pulse on an aborted write
//            o_mem_* / i_mem_*     IOb request / response
// Revision : 1.0 - initial release
// ============================================================================
module iob_vexriscv_bus_bridge #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 0,
   parameter int TIMEOUT_W = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_cpu_cmd_valid,
   output logic                o_cpu_cmd_ready,
   input  logic                i_cpu_cmd_wr,
   input  logic [ADDR_W-1:0]   i_cpu_cmd_addr,
   input  logic [31:0]         i_cpu_cmd_data,
   input  logic [1:0]          i_cpu_cmd_size,
   output logic                o_cpu_rsp_valid,
   output logic                o_cpu_rsp_error,
   output logic [31:0]         o_cpu_rsp_data,
   output logic                o_wr_err,
   output logic                o_mem_valid,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [DATA_W/8-1:0] o_mem_wstrb,
   input  logic                i_mem_ready,
   input  logic [DATA_W-1:0]   i_mem_rdata
);

   localparam int c_NW     = DATA_W / 32;
   localparam int c_STRB_W = DATA_W / 8;
   localparam int c_L      = $clog2(c_STRB_W);
   localparam int c_WI_W   = (c_L > 2) ? (c_L - 2) : 1;
   localparam logic [TIMEOUT_W-1:0] c_TO_LAST =
      TIMEOUT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_mem_valid, w_mem_valid_nxt;
   logic [ADDR_W-1:0]     r_mem_addr, w_mem_addr_nxt;
   logic [DATA_W-1:0]     r_mem_wdata, w_mem_wdata_nxt;
   logic [c_STRB_W-1:0]   r_mem_wstrb, w_mem_wstrb_nxt;
   logic                  r_wr, w_wr_nxt;
   logic [c_WI_W-1:0]     r_word, w_word_nxt;
   logic                  r_rsp_valid, w_rsp_valid_nxt;
   logic                  r_rsp_error, w_rsp_error_nxt;
   logic [31:0]           r_rsp_data, w_rsp_data_nxt;
   logic                  r_wr_err, w_wr_err_nxt;
   logic [TIMEOUT_W-1:0]  r_cnt, w_cnt_nxt;

   logic                  w_accept;
   logic                  w_misaligned;
   logic [c_L-1:0]        w_off;
   logic [c_STRB_W-1:0]   w_mask;
   logic [c_STRB_W-1:0]   w_wstrb;
   logic [c_WI_W-1:0]     w_word;
   logic [31:0]           w_rd_word;
   logic                  w_to_hit;

   // ---------------------------------------------------------------------
   // Command decode
   // ---------------------------------------------------------------------
   assign w_accept = i_cpu_cmd_valid && (r_state == ST_IDLE);
   assign w_off    = i_cpu_cmd_addr[c_L-1:0];

   assign w_misaligned = (i_cpu_cmd_size == 2'd3) ||
                         ((i_cpu_cmd_size == 2'd1) && i_cpu_cmd_addr[0]) ||
                         ((i_cpu_cmd_size == 2'd2) && (i_cpu_cmd_addr[1:0] != 2'b00));

   always_comb begin
      w_mask = '0;
      case (i_cpu_cmd_size)
         2'd0:    w_mask[0]   = 1'b1;
         2'd1:    w_mask[1:0] = 2'b11;
         default: w_mask[3:0] = 4'hF;
      endcase
   end

   assign w_wstrb = i_cpu_cmd_wr ? (w_mask << w_off) : '0;

   // Which 32-bit lane of the memory word holds the addressed CPU word.
   generate
      if (c_L > 2) begin : g_word_wide
         assign w_word = i_cpu_cmd_addr[c_L-1:2];
      end else begin : g_word_narrow
         assign w_word = '0;
      end
   endgenerate

   always_comb begin
      w_rd_word = i_mem_rdata[31:0];
      for (int i = 0; i < c_NW; i++) begin
         if (r_word == c_WI_W'(i)) w_rd_word = i_mem_rdata[32*i +: 32];
      end
   end

   assign w_to_hit = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);

   // ---------------------------------------------------------------------
   // Next-state / next-output logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_mem_valid_nxt = r_mem_valid;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_mem_wstrb_nxt = r_mem_wstrb;
      w_wr_nxt        = r_wr;
      w_word_nxt      = r_word;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_error_nxt = 1'b0;
      w_rsp_data_nxt  = r_rsp_data;
      w_wr_err_nxt    = 1'b0;
      w_cnt_nxt       = '0;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_misaligned) begin
                  if (i_cpu_cmd_wr) begin
                     w_wr_err_nxt = 1'b1;
                  end else begin
                     w_state_nxt     = ST_RSP;
                     w_rsp_valid_nxt = 1'b1;
                     w_rsp_error_nxt = 1'b1;
                     w_rsp_data_nxt  = '0;
                  end
               end else begin
                  w_state_nxt     = ST_REQ;
                  w_mem_valid_nxt = 1'b1;
                  w_mem_addr_nxt  = {i_cpu_cmd_addr[ADDR_W-1:c_L], {c_L{1'b0}}};
                  w_mem_wdata_nxt = {c_NW{i_cpu_cmd_data}};
                  w_mem_wstrb_nxt = w_wstrb;
                  w_wr_nxt        = i_cpu_cmd_wr;
                  w_word_nxt      = w_word;
               end
            end
         end

         ST_REQ: begin
            // mem_ready takes priority over a timeout in the same cycle
            if (i_mem_ready) begin
               w_mem_valid_nxt = 1'b0;
               if (r_wr) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt     = ST_RSP;
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_data_nxt  = w_rd_word;
               end
            end else if (w_to_hit) begin
               w_mem_valid_nxt = 1'b0;
               if (r_wr) begin
                  w_state_nxt  = ST_IDLE;
                  w_wr_err_nxt = 1'b1;
               end else begin
                  w_state_nxt     = ST_RSP;
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_error_nxt = 1'b1;
                  w_rsp_data_nxt  = '0;
               end
            end else begin
               w_cnt_nxt = r_cnt + TIMEOUT_W'(1);
            end
         end

         ST_RSP: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt     = ST_IDLE;
            w_mem_valid_nxt = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_mem_valid <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
         r_wr        <= 1'b0;
         r_word      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_error <= 1'b0;
         r_rsp_data  <= '0;
         r_wr_err    <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_mem_valid <= w_mem_valid_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_wstrb <= w_mem_wstrb_nxt;
         r_wr        <= w_wr_nxt;
         r_word      <= w_word_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_error <= w_rsp_error_nxt;
         r_rsp_data  <= w_rsp_data_nxt;
         r_wr_err    <= w_wr_err_nxt;
         r_cnt       <= w_cnt_nxt;
      end
   end

   assign o_cpu_cmd_ready = (r_state == ST_IDLE);
   assign o_cpu_rsp_valid = r_rsp_valid;
   assign o_cpu_rsp_error = r_rsp_error;
   assign o_cpu_rsp_data  = r_rsp_data;
   assign o_wr_err        = r_wr_err;
   assign o_mem_valid     = r_mem_valid;
   assign o_mem_addr      = r_mem_addr;
   assign o_mem_wdata     = r_mem_wdata;
   assign o_mem_wstrb     = r_mem_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_iob_vexriscv_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_vexriscv_bus_bridge
// Purpose  : Self-checking bench for iob_vexriscv_bus_bridge (DATA_W=64,
//            TIMEOUT=4). Directed cases followed by randomized transactions
//            checked against a behavioural model of the bridge rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_vexriscv_bus_bridge;

   localparam int DW = 64;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_wr = 1'b0;
   logic [31:0]   cmd_addr = '0;
   logic [31:0]   cmd_data = '0;
   logic [1:0]    cmd_size = '0;
   logic          rsp_valid;
   logic          rsp_error;
   logic [31:0]   rsp_data;
   logic          wr_err;
   logic          mem_valid;
   logic [31:0]   mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW/8-1:0] mem_wstrb;
   logic          mem_ready = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   int n_chk = 0;
   int n_err = 0;
   int n_acc = 0;
   int n_exp = 0;

   iob_vexriscv_bus_bridge #(
      .ADDR_W(32), .DATA_W(DW), .TIMEOUT(TO), .TIMEOUT_W(16)
   ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cpu_cmd_valid(cmd_valid), .o_cpu_cmd_ready(cmd_ready),
      .i_cpu_cmd_wr(cmd_wr), .i_cpu_cmd_addr(cmd_addr),
      .i_cpu_cmd_data(cmd_data), .i_cpu_cmd_size(cmd_size),
      .o_cpu_rsp_valid(rsp_valid), .o_cpu_rsp_error(rsp_error),
      .o_cpu_rsp_data(rsp_data), .o_wr_err(wr_err),
      .o_mem_valid(mem_valid), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
      .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Count every handshake the DUT takes, to prove each command goes in once
   always @(posedge clk) begin
      if (rst_n && cmd_valid && cmd_ready) n_acc++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One CPU transaction. d = cycles of mem_valid before mem_ready is raised.
   task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] data, input int d, input logic [63:0] rdata,
                         input bit keep);
      logic [63:0] e_addr, e_wdata, e_rd;
      logic [7:0]  mask, e_strb;
      bit          mis, to;
      int          e, word;

      // Reference model: bridge rules computed with plain arithmetic
      mis    = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
               (size == 2'd2 && (addr % 4) != 0);
      mask   = (size == 2'd0) ? 8'h01 : (size == 2'd1) ? 8'h03 : 8'h0F;
      e_strb = wr ? 8'(mask << (addr % (DW/8))) : 8'h00;
      e_addr = 64'(addr - (addr % (DW/8)));
      e_wdata = 64'(data) * 64'h0000_0001_0000_0001;
      word   = int'((addr % (DW/8)) / 4);
      e_rd   = (rdata >> (32*word)) & 64'hFFFF_FFFF;
      to     = (TO != 0) && (d >= TO);
      e      = to ? TO - 1 : d;
      n_exp++;

      chk("ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_size = size; cmd_data = data;
      mem_ready = 1'($urandom_range(0, 1));   // must be ignored outside REQ
      mem_rdata = {$urandom, $urandom};
      step();
      if (!keep) cmd_valid = 1'b0;
      mem_ready = 1'b0;

      if (mis) begin
         chk("mis_no_mem", mem_valid, 0);
         if (wr) begin
            chk("mis_wr_err", wr_err, 1);
            chk("mis_wr_no_rsp", rsp_valid, 0);
            chk("mis_wr_ready", cmd_ready, 1);
            step();
            chk("wr_err_pulse", wr_err, 0);
         end else begin
            chk("mis_rsp_valid", rsp_valid, 1);
            chk("mis_rsp_error", rsp_error, 1);
            chk("mis_rsp_data", rsp_data, 0);
            chk("mis_rsp_busy", cmd_ready, 0);
            step();
            chk("mis_rsp_one", rsp_valid, 0);
            chk("mis_ready_back", cmd_ready, 1);
         end
      end else begin
         for (int c = 0; c <= e; c++) begin
            chk("mem_valid", mem_valid, 1);
            chk("req_busy", cmd_ready, 0);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wstrb", mem_wstrb, e_strb);
            chk("mem_wdata", mem_wdata, e_wdata);
            if (c == d) begin
               mem_ready = 1'b1; mem_rdata = rdata;
            end else begin
               mem_ready = 1'b0; mem_rdata = {$urandom, $urandom};
            end
            step();
         end
         mem_ready = 1'b0;
         chk("mem_valid_drop", mem_valid, 0);
         if (wr) begin
            chk("wr_err", wr_err, to);
            chk("wr_no_rsp", rsp_valid, 0);
            chk("wr_ready_back", cmd_ready, 1);
            if (to) begin
               step();
               chk("wr_err_pulse", wr_err, 0);
            end
         end else begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_error", rsp_error, to);
            chk("rsp_data", rsp_data, to ? 64'h0 : e_rd);
            chk("rsp_busy", cmd_ready, 0);
            step();
            chk("rsp_one", rsp_valid, 0);
            chk("ready_back", cmd_ready, 1);
         end
      end
   endtask

   initial begin
      repeat (2) step();
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wstrb", mem_wstrb, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_error", rsp_error, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_wr_err", wr_err, 0);
      chk("rst_ready", cmd_ready, 1);
      rst_n = 1'b1;
      step();

      // Directed cases
      do_txn(0, 32'h100, 2, 32'h0, 0, 64'h0000_0000_DEAD_BEEF, 0);
      do_txn(1, 32'h106, 1, 32'h0000_ABCD, 0, 64'h0, 0);
      do_txn(0, 32'h104, 2, 32'h0, 1, 64'h1122_3344_5566_7788, 0);
      do_txn(0, 32'h102, 2, 32'h0, 0, 64'h0, 0);
      do_txn(1, 32'h101, 1, 32'h1234, 0, 64'h0, 0);
      do_txn(0, 32'h100, 3, 32'h0, 0, 64'h0, 0);
      do_txn(0, 32'h200, 2, 32'h0, 20, 64'hAAAA_BBBB_CCCC_DDDD, 0);
      do_txn(1, 32'h203, 0, 32'h55, 20, 64'h0, 0);
      do_txn(0, 32'h20C, 2, 32'h0, 3, 64'hAAAA_BBBB_CCCC_DDDD, 0);
      do_txn(1, 32'h20E, 1, 32'h77, 3, 64'h0, 0);

      // Backpressure: cmd_valid held high across 5 queued reads
      for (int i = 0; i < 5; i++)
         do_txn(0, 32'h300 + 32'(4*i), 2, 32'h0, 3, {$urandom, $urandom}, 1);
      cmd_valid = 1'b0;
      step();

      // Reset in the middle of a request
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h400; cmd_size = 2'd2;
      n_exp++;
      step();
      cmd_valid = 1'b0;
      chk("pre_rst_mem_valid", mem_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_mem_valid", mem_valid, 0);
      chk("async_rst_ready", cmd_ready, 1);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b1;
         step();
         chk("post_rst_no_rsp", rsp_valid, 0);
         chk("post_rst_no_mem", mem_valid, 0);
      end
      mem_ready = 1'b0;

      // Randomized transactions
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
            chk("idle_ready_ignored", mem_valid, 0);
            chk("idle_no_rsp", rsp_valid, 0);
         end
         do_txn(1'($urandom_range(0, 1)), 32'h2000 + ($urandom & 32'hFF),
                2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 5),
                {$urandom, $urandom}, 0);
      end

      step();
      chk("accept_count", 64'(n_acc), 64'(n_exp));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
